// File: rtl/time_set_ctrl_pkg.sv
// time_set_ctrl_pkg: state encodings and helpers shared by the clock time-set blocks
package time_set_ctrl_pkg;
  localparam int STATE_W = 2;
  typedef logic [STATE_W-1:0] state_t;
  localparam state_t RUN     = 2'd0;
  localparam state_t SET_H   = 2'd1;
  localparam state_t SET_M10 = 2'd2;
  localparam state_t SET_M1  = 2'd3;
  // The mode cycle is a plain wrap-around count through the four states.
  function automatic state_t next_mode(input state_t s);
    return s + 2'd1;
  endfunction
endpackage

// File: rtl/edge_det.sv
// edge_det: one-cycle rising-edge pulse; history resets high so a level already high at reset release is not an edge
module edge_det (
  input  logic in_clk,
  input  logic rst,
  input  logic d,
  output logic pulse
);
  logic prev_q;
  always_ff @(posedge in_clk) begin
    if (!rst) prev_q <= 1'b1;
    else      prev_q <= d;
  end
  assign pulse = d & ~prev_q;
endmodule

// File: rtl/time_set_ctrl.sv
// time_set_ctrl: run/set mode FSM issuing registered digit-increment pulses and a field blink enable
module time_set_ctrl
  import time_set_ctrl_pkg::*;
(
  input  logic                in_clk,
  input  logic                rst,
  input  logic                clk_s10,
  input  logic                clk_m1,
  input  logic                mode_btn,
  input  logic                inc_btn,
  input  logic                m1_max,
  input  logic                m10_max,
  output logic                inc_m1,
  output logic                inc_m10,
  output logic                inc_h,
  output logic [STATE_W-1:0]  mode,
  output logic                blink
);
  logic s10_e, m1_e, mode_e, inc_e;
  logic run, tick, set_inc;
  state_t state_q, state_d;
  logic blink_q, blink_d;
  logic inc_m1_q, inc_m1_d, inc_m10_q, inc_m10_d, inc_h_q, inc_h_d;

  edge_det u_s10  (.in_clk(in_clk), .rst(rst), .d(clk_s10),  .pulse(s10_e));
  edge_det u_m1   (.in_clk(in_clk), .rst(rst), .d(clk_m1),   .pulse(m1_e));
  edge_det u_mode (.in_clk(in_clk), .rst(rst), .d(mode_btn), .pulse(mode_e));
  edge_det u_inc  (.in_clk(in_clk), .rst(rst), .d(inc_btn),  .pulse(inc_e));

  assign run = state_q == RUN;
  // A mode press wins over a simultaneous increment press.
  assign tick    = run & m1_e;
  assign set_inc = ~run & inc_e & ~mode_e;

  always_comb begin
    state_d   = mode_e ? next_mode(state_q) : state_q;
    blink_d   = (mode_e | run) ? 1'b0 : blink_q ^ s10_e;
    inc_m1_d  = tick | (set_inc & (state_q == SET_M1));
    inc_m10_d = (tick & m1_max) | (set_inc & (state_q == SET_M10));
    inc_h_d   = (tick & m1_max & m10_max) | (set_inc & (state_q == SET_H));
  end

  always_ff @(posedge in_clk) begin
    if (!rst) begin
      state_q   <= RUN;
      blink_q   <= 1'b0;
      inc_m1_q  <= 1'b0;
      inc_m10_q <= 1'b0;
      inc_h_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      blink_q   <= blink_d;
      inc_m1_q  <= inc_m1_d;
      inc_m10_q <= inc_m10_d;
      inc_h_q   <= inc_h_d;
    end
  end

  assign mode    = state_q;
  assign blink   = blink_q;
  assign inc_m1  = inc_m1_q;
  assign inc_m10 = inc_m10_q;
  assign inc_h   = inc_h_q;
endmodule

// File: tb/tb_time_set_ctrl.sv
// tb_time_set_ctrl: directed and random stimulus against a behavioural model, checked through an expected-output queue
module tb_time_set_ctrl;
  logic in_clk, rst, clk_s10, clk_m1, mode_btn, inc_btn, m1_max, m10_max;
  logic inc_m1, inc_m10, inc_h, blink;
  logic [1:0] mode;

  logic v_rst, v_s10, v_m1, v_mb, v_ib, v_mx1, v_mx10;
  int st;
  bit bl, o_m1, o_m10, o_h;
  bit p_s10, p_m1, p_mb, p_ib;
  logic [5:0] exp_q[$];
  int checks = 0, errors = 0, cycle = 0;

  time_set_ctrl dut (
    .in_clk(in_clk), .rst(rst), .clk_s10(clk_s10), .clk_m1(clk_m1),
    .mode_btn(mode_btn), .inc_btn(inc_btn), .m1_max(m1_max), .m10_max(m10_max),
    .inc_m1(inc_m1), .inc_m10(inc_m10), .inc_h(inc_h), .mode(mode), .blink(blink)
  );

  initial in_clk = 1'b0;
  always #5 in_clk = ~in_clk;

  // Reference behaviour: what the outputs must show after the coming rising edge.
  task automatic model_step();
    bit e_s10, e_m1, e_mb, e_ib;
    if (!v_rst) begin
      st = 0; bl = 0; o_m1 = 0; o_m10 = 0; o_h = 0;
      p_s10 = 1; p_m1 = 1; p_mb = 1; p_ib = 1;
    end else begin
      e_s10 = v_s10 && !p_s10;
      e_m1  = v_m1 && !p_m1;
      e_mb  = v_mb && !p_mb;
      e_ib  = v_ib && !p_ib;
      o_m1 = 0; o_m10 = 0; o_h = 0;
      if (st == 0 && e_m1) begin
        o_m1 = 1; o_m10 = v_mx1; o_h = v_mx1 && v_mx10;
      end
      if (st != 0 && e_ib && !e_mb) begin
        o_h = (st == 1); o_m10 = (st == 2); o_m1 = (st == 3);
      end
      if (e_mb) begin
        st = (st + 1) % 4; bl = 0;
      end else if (st != 0 && e_s10) bl = !bl;
      p_s10 = v_s10; p_m1 = v_m1; p_mb = v_mb; p_ib = v_ib;
    end
    exp_q.push_back({st[1:0], bl, o_h, o_m10, o_m1});
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(negedge in_clk);
      rst = v_rst; clk_s10 = v_s10; clk_m1 = v_m1; mode_btn = v_mb;
      inc_btn = v_ib; m1_max = v_mx1; m10_max = v_mx10;
      model_step();
    end
  endtask

  task automatic press_mode(); v_mb = 1; cyc(1); v_mb = 0; cyc(1); endtask
  task automatic press_inc();  v_ib = 1; cyc(1); v_ib = 0; cyc(1); endtask
  task automatic rise_m1();    v_m1 = 0; cyc(1); v_m1 = 1; cyc(1); endtask
  task automatic rise_s10();   v_s10 = 1; cyc(1); v_s10 = 0; cyc(1); endtask

  initial begin
    logic [5:0] e, g;
    forever begin
      @(posedge in_clk);
      #1;
      cycle++;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        g = {mode, blink, inc_h, inc_m10, inc_m1};
        checks++;
        if (g !== e) begin
          errors++;
          $display("FAIL outputs@cycle%0d got mode=%0d blink=%b h/m10/m1=%b%b%b expected mode=%0d blink=%b h/m10/m1=%b%b%b",
                   cycle, g[5:4], g[3], g[2], g[1], g[0], e[5:4], e[3], e[2], e[1], e[0]);
        end
      end
    end
  end

  initial begin
    v_rst = 0; v_s10 = 0; v_m1 = 1; v_mb = 0; v_ib = 0; v_mx1 = 0; v_mx10 = 0;
    rst = 0; clk_s10 = 0; clk_m1 = 1; mode_btn = 0; inc_btn = 0; m1_max = 0; m10_max = 0;
    cyc(3);
    v_rst = 1; cyc(10);
    v_mx1 = 1; v_mx10 = 1; rise_m1(); cyc(3);
    v_mx1 = 0; rise_m1(); cyc(3);
    repeat (3) press_mode();
    press_inc(); press_inc(); cyc(2);
    press_mode();
    press_mode();
    repeat (5) rise_m1();
    press_inc();
    repeat (3) press_mode();
    cyc(6);
    repeat (2) press_mode();
    v_mb = 1; v_ib = 1; cyc(1); v_mb = 0; v_ib = 0; cyc(2);
    press_mode();
    press_mode();
    repeat (4) rise_s10();
    press_mode();
    repeat (2) press_mode();
    v_mx1 = 1; v_mx10 = 1;
    v_m1 = 0; cyc(1); v_m1 = 1; cyc(1);
    v_rst = 0; cyc(1); v_rst = 1; cyc(4);
    repeat (3000) begin
      v_rst  = ($urandom_range(0, 199) != 0);
      v_s10  = ($urandom_range(0, 2) == 0) ? ~v_s10 : v_s10;
      v_m1   = ($urandom_range(0, 3) == 0) ? ~v_m1 : v_m1;
      v_mb   = ($urandom_range(0, 5) == 0) ? ~v_mb : v_mb;
      v_ib   = ($urandom_range(0, 2) == 0) ? ~v_ib : v_ib;
      v_mx1  = 1'($urandom_range(0, 1));
      v_mx10 = 1'($urandom_range(0, 1));
      cyc(1);
    end
    v_rst = 1; cyc(2);
    repeat (3) @(posedge in_clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/time_set_ctrl.md
TIME_SET_CTRL -- requirements
Module: time_set_ctrl

Interface
REQ-001 SHALL have a single clock domain. Reset is synchronous and active-low.
REQ-002 SHALL have port `in_clk`: input, 1 bit, system clock; all logic rising-edge.
REQ-003 SHALL have port `rst`: input, 1 bit, synchronous active-low reset.
REQ-004 SHALL have port `clk_s10`: input, 1 bit, divider output level; each rising edge is a blink tick.
REQ-005 SHALL have port `clk_m1`: input, 1 bit, divider output level; each rising edge is a one-minute tick.
REQ-006 SHALL have port `mode_btn`: input, 1 bit, debounced level; each rising edge is one mode press.
REQ-007 SHALL have port `inc_btn`: input, 1 bit, debounced level; each rising edge is one increment press.
REQ-008 SHALL have port `m1_max`: input, 1 bit, minute-units counter is at 9.
REQ-009 SHALL have port `m10_max`: input, 1 bit, minute-tens counter is at 5.
REQ-010 SHALL have ports `inc_m1`, `inc_m10`, `inc_h`: output, 1 bit each, registered one-cycle increment enables to the digit counters; counters self-wrap.
REQ-011 SHALL have port `mode`: output, 2 bits, current state encoding.
REQ-012 SHALL have port `blink`: output, 1 bit, display blank enable for the selected field.

Function
REQ-013 SHALL detect a rising edge on each of `clk_s10`, `clk_m1`, `mode_btn` and `inc_btn` as: current sample = 1 and previous-cycle sample = 0.
REQ-014 SHALL implement FSM states RUN=0, SET_H=1, SET_M10=2, SET_M1=3. `mode` equals the state register.
REQ-015 SHALL advance the state on a `mode_btn` edge: RUN -> SET_H -> SET_M10 -> SET_M1 -> RUN. No other transitions exist.
REQ-016 SHALL, in RUN, respond to a `clk_m1` edge detected in cycle N with, in cycle N+1 only:
  - `inc_m1` = 1
  - `inc_m10` = `m1_max`
  - `inc_h` = `m1_max` & `m10_max`
  - all three evaluated from the values sampled in cycle N.
REQ-017 SHALL, in RUN, ignore `inc_btn` edges.
REQ-018 SHALL, in any SET state, drop `clk_m1` edges; they are not queued or replayed.
REQ-019 SHALL, in SET_H / SET_M10 / SET_M1, respond to an `inc_btn` edge detected in cycle N by pulsing `inc_h` / `inc_m10` / `inc_m1` respectively, alone, in cycle N+1, with no carry.
REQ-020 SHALL, when `mode_btn` and `inc_btn` edges occur in the same cycle, take the mode transition and discard the increment.
REQ-021 SHALL, when `mode_btn` and `clk_m1` edges occur in the same RUN cycle, issue the RUN tick response (REQ-016) and take the transition.
REQ-022 SHALL update the edge-history registers every cycle in all states, so returning to RUN with `clk_m1` already high produces no tick.
REQ-023 SHALL hold `blink` at 0 in RUN.
REQ-024 SHALL, in SET states, toggle `blink` on each `clk_s10` edge, and clear `blink` to 0 in the cycle following any state change.
REQ-025 SHALL never assert more than one `inc_*` output per cycle in SET states.
REQ-026 SHALL keep every `inc_*` output at most one cycle wide per edge event.

Reset
REQ-027 SHALL, while `rst`=0 at a rising `in_clk`, set:
  - state = RUN
  - `inc_m1` = `inc_m10` = `inc_h` = 0
  - `blink` = 0
  - `mode` = 0
REQ-028 SHALL reset all edge-history registers to 1, so inputs already high at reset release produce no edge.
REQ-029 SHALL, on reset asserted mid-operation (any state, pending pulse), abort on that clock edge; no pending `inc_*` pulse is emitted afterwards.

Structure
REQ-030 SHALL place the state encodings (RUN, SET_H, SET_M10, SET_M1) and the 2-bit state width constant in a shared package with the hour-counter blocks.
REQ-031 SHALL implement edge detection in one sub-module, `edge_det` (synchronous active-low reset, reset history = 1, output 1-cycle pulse), instantiated four times.

Verification
REQ-032 SHALL verify: reset with `clk_m1`=1, release, hold 10 cycles -> no `inc_*` pulse; `mode`=0; `blink`=0.
REQ-033 SHALL verify: RUN, `m1_max`=1, `m10_max`=1, `clk_m1` 0->1 -> exactly one cycle later `inc_m1`=`inc_m10`=`inc_h`=1 for 1 cycle; with `m1_max`=0, only `inc_m1`=1.
REQ-034 SHALL verify: 3 `mode_btn` presses, then 2 `inc_btn` presses -> `mode`=3; two single-cycle `inc_m1` pulses; `inc_m10`=`inc_h`=0 throughout.
REQ-035 SHALL verify: SET_H, 5 `clk_m1` edges plus 1 `inc_btn` press -> exactly one `inc_h` pulse; no `inc_m1`; after return to RUN with `clk_m1` high, no tick.
REQ-036 SHALL verify: SET_M10, `mode_btn` and `inc_btn` rise in the same cycle -> `mode`=3 next cycle; no `inc_m10` pulse.
REQ-037 SHALL verify: SET_H, 4 `clk_s10` edges -> `blink` toggles 4 times; `mode` press -> `blink`=0 next cycle; `rst`=0 mid-pulse -> all outputs 0 on that edge.
